cpu_control: RTL and testbench
==============================

Name: cpu_control

Overview:
- Instruction register plus Moore control FSM that sits directly upstream of the datapath.
- Latches a 16-bit instruction and decodes its fields (register numbers, shift, ALU op, immediates).
- Sequences the datapath's register-file, A/B/C register and status enables over several cycles per instruction.
- Handshake with the test harness/top level is `s` (start) and `w` (waiting).

Parameters:
- None. All widths are fixed by the instruction format.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in  input  16  instruction word to latch
load  input  1  latch `in` into IR (accepted only in WAIT)
s  input  1  start execution of the IR contents (accepted only in WAIT)
w  output  1  1 while in WAIT (idle, ready)
readnum  output  3  register-file read address
writenum  output  3  register-file write address
write  output  1  register-file write enable
vsel  output  2  write-back source select: 00 = C, 10 = sximm8
loada  output  1  load datapath A register
loadb  output  1  load datapath B register
asel  output  1  1 forces ALU A input to zero
bsel  output  1  1 selects sximm5 for ALU B input
loadc  output  1  load datapath C register
loads  output  1  load datapath status register
shift  output  2  shifter control
ALUop  output  2  ALU operation
sximm8  output  16  sign-extended IR[7:0]
sximm5  output  16  sign-extended IR[4:0]

Behaviour:
- IR fields:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], shamt = IR[4:3], Rm = IR[2:0]
- Supported instructions:
  - MOV Rn,#im8: opcode 110, op 10
  - MOV Rd,Rm{,sh}: opcode 110, op 00
  - ADD: opcode 101, op 00
  - CMP: opcode 101, op 01
  - AND: opcode 101, op 10
  - MVN: opcode 101, op 11
  - Everything else is undefined.
- IR update: IR <= `in` at a clock edge when load=1 and state=WAIT. Otherwise IR holds. `load` outside WAIT is ignored.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG.
- Transitions:
  - WAIT: s=1 -> DECODE; else stay.
  - DECODE:
    - MOV imm -> WRITE_IMM
    - MOV reg -> GET_B
    - opcode 101 -> GET_A
    - undefined -> WAIT
  - WRITE_IMM -> WAIT.
  - GET_A -> GET_B.
  - GET_B -> EXEC.
  - EXEC: CMP -> WAIT; otherwise -> WRITE_REG.
  - WRITE_REG -> WAIT.
- Outputs are decoded from state and IR only (Moore). All enables, readnum, writenum and vsel are 0 unless listed below.
  - WAIT: w=1.
  - WRITE_IMM: writenum=Rn, vsel=10, write=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC:
    - loadc=1
    - asel=1 for MOV reg, else 0
    - loads=1 only for CMP
  - WRITE_REG: writenum=Rd, vsel=00, write=1.
- ALUop = op when opcode=101, else 00.
- shift = shamt for opcode 101 or MOV reg, else 00.
- bsel is always 0.
- sximm8 and sximm5 are continuous sign extensions of IR, valid in every state.
- load and s in the same WAIT cycle: the new IR value is captured, and DECODE acts on the new value.
- s outside WAIT is ignored.
- Latency (cycles with w=0, counted from the edge sampling s):
  - MOV imm: 2
  - MOV reg: 4
  - CMP: 4
  - ADD / AND / MVN: 5
  - undefined: 1
- Exactly one write pulse per writing instruction.
- Reset, at any time including mid-instruction:
  - state -> WAIT and IR -> 0, immediately.
  - w=1; all enables, readnum, writenum, vsel, shift, ALUop = 0; sximm8 = sximm5 = 0.
  - No partial write occurs after reset asserts.

Test Plan:
- Reset asserted during EXEC of ADD -> same cycle w=1, loadc=0, write=0; after release, FSM stays in WAIT until s.
- load in=16'hD0FD (MOV R0,#-3), s=1 -> DECODE, then WRITE_IMM with write=1, writenum=0, vsel=10, sximm8=16'hFFFD; w=1 on the next cycle.
- IR=16'hA148 (ADD R2,R1,R0 LSL#1):
  - GET_A: readnum=1, loada=1.
  - GET_B: readnum=0, loadb=1.
  - EXEC: ALUop=00, shift=01, asel=0, loadc=1, loads=0.
  - WRITE_REG: writenum=2, vsel=00, write=1.
  - w low for 5 cycles.
- IR=16'hA900 (CMP R1,R0) -> EXEC has loadc=1, loads=1, ALUop=01; write never asserts; WAIT after 4 cycles.
- Start ADD, then pulse load with 16'hD0FD during GET_B -> IR unchanged, ADD completes normally. Then load+s together in WAIT -> MOV imm executes.
- IR=16'hE000 (undefined) -> DECODE for one cycle, then WAIT; no enable ever asserts.

Source files
------------

// File: rtl/cpu_control.sv
// Instruction register plus Moore control FSM sequencing the datapath enables.
// Latency: outputs are registered; w drops the cycle after s is sampled in WAIT, 1-5 busy cycles per instruction.
// Backpressure: none; load and s are accepted only in WAIT (w=1) and ignored otherwise.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in, load, s       instruction word, IR latch strobe, start strobe
//   w                 high while idle in WAIT
//   readnum/writenum  register-file addresses; write = register-file write enable
//   vsel              write-back source (00 = C, 10 = sximm8)
//   loada/loadb/loadc/loads, asel, bsel  datapath register enables and ALU operand selects
//   shift, ALUop      shifter / ALU controls decoded from IR
//   sximm8, sximm5    sign-extended immediates from IR
module cpu_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  state_t      state;
  logic [15:0] ir;

  // Next-cycle values. Outputs are registered from the next state and next IR,
  // so each output register always equals the Moore decode of (state, ir).
  state_t      state_nxt;
  logic [15:0] ir_nxt;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic        is_mov_imm;
  logic        is_mov_reg;
  logic        is_alu;
  logic        is_cmp;

  logic        w_nxt;
  logic [2:0]  readnum_nxt;
  logic [2:0]  writenum_nxt;
  logic        write_nxt;
  logic [1:0]  vsel_nxt;
  logic        loada_nxt;
  logic        loadb_nxt;
  logic        asel_nxt;
  logic        loadc_nxt;
  logic        loads_nxt;
  logic [1:0]  shift_nxt;
  logic [1:0]  aluop_nxt;

  always_comb begin
    ir_nxt = (load && (state == S_WAIT)) ? in : ir;

    opcode     = ir_nxt[15:13];
    op         = ir_nxt[12:11];
    is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    is_alu     = (opcode == 3'b101);
    is_cmp     = is_alu && (op == 2'b01);

    // IR only changes in WAIT, so decisions taken in later states see the
    // same instruction through ir_nxt as through ir.
    state_nxt = S_WAIT;
    case (state)
      S_WAIT:      state_nxt = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_mov_imm)      state_nxt = S_WRITE_IMM;
        else if (is_mov_reg) state_nxt = S_GET_B;
        else if (is_alu)     state_nxt = S_GET_A;
        else                 state_nxt = S_WAIT;
      end
      S_WRITE_IMM: state_nxt = S_WAIT;
      S_GET_A:     state_nxt = S_GET_B;
      S_GET_B:     state_nxt = S_EXEC;
      S_EXEC:      state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase

    w_nxt        = 1'b0;
    readnum_nxt  = 3'd0;
    writenum_nxt = 3'd0;
    write_nxt    = 1'b0;
    vsel_nxt     = 2'b00;
    loada_nxt    = 1'b0;
    loadb_nxt    = 1'b0;
    asel_nxt     = 1'b0;
    loadc_nxt    = 1'b0;
    loads_nxt    = 1'b0;
    case (state_nxt)
      S_WAIT: w_nxt = 1'b1;
      S_WRITE_IMM: begin
        writenum_nxt = ir_nxt[10:8];
        vsel_nxt     = 2'b10;
        write_nxt    = 1'b1;
      end
      S_GET_A: begin
        readnum_nxt = ir_nxt[10:8];
        loada_nxt   = 1'b1;
      end
      S_GET_B: begin
        readnum_nxt = ir_nxt[2:0];
        loadb_nxt   = 1'b1;
      end
      S_EXEC: begin
        loadc_nxt = 1'b1;
        asel_nxt  = is_mov_reg;  // MOV reg passes B through as 0 + B
        loads_nxt = is_cmp;
      end
      S_WRITE_REG: begin
        writenum_nxt = ir_nxt[7:5];
        write_nxt    = 1'b1;
      end
      default: ;
    endcase

    // ALU/shifter controls depend on the instruction only, not on the state.
    shift_nxt = (is_alu || is_mov_reg) ? ir_nxt[4:3] : 2'b00;
    aluop_nxt = is_alu ? op : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      ir       <= 16'd0;
      w        <= 1'b1;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      vsel     <= 2'b00;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
    end else begin
      state    <= state_nxt;
      ir       <= ir_nxt;
      w        <= w_nxt;
      readnum  <= readnum_nxt;
      writenum <= writenum_nxt;
      write    <= write_nxt;
      vsel     <= vsel_nxt;
      loada    <= loada_nxt;
      loadb    <= loadb_nxt;
      asel     <= asel_nxt;
      loadc    <= loadc_nxt;
      loads    <= loads_nxt;
      shift    <= shift_nxt;
      ALUop    <= aluop_nxt;
    end
  end

  assign bsel   = 1'b0;
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  cpu_control dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sx8;
    logic [15:0] sx5;
  } ctl_t;

  ctl_t obs;
  always_comb obs = {w, readnum, writenum, write, vsel, loada, loadb, asel,
                     bsel, loadc, loads, shift, ALUop, sximm8, sximm5};

  int   tests = 0;
  int   fails = 0;
  ctl_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input ctl_t exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction-only fields; every control enable left at 0.
  function automatic ctl_t base(input logic [15:0] ir);
    ctl_t c;
    int   v8;
    int   v5;
    logic [2:0] opc;
    logic [1:0] op;
    c   = '0;
    opc = ir[15:13];
    op  = ir[12:11];
    if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) c.shift = ir[4:3];
    if (opc == 3'b101) c.aluop = op;
    v8 = int'(ir[7:0]);
    if (v8 > 127) v8 -= 256;
    v5 = int'(ir[4:0]);
    if (v5 > 15) v5 -= 32;
    c.sx8 = 16'(v8);
    c.sx5 = 16'(v5);
    return c;
  endfunction

  function automatic ctl_t idle(input logic [15:0] ir);
    ctl_t c;
    c   = base(ir);
    c.w = 1'b1;
    return c;
  endfunction

  // Expected output per busy cycle (w=0) for one instruction.
  function automatic void build_expect(input logic [15:0] ir);
    ctl_t b, c;
    logic [4:0] key;
    exp_q.delete();
    b   = base(ir);
    key = ir[15:11];
    exp_q.push_back(b);  // decode cycle: nothing enabled
    if (key == 5'b11010) begin
      c = b; c.writenum = ir[10:8]; c.vsel = 2'b10; c.write = 1'b1;
      exp_q.push_back(c);
    end else if (key == 5'b11000 || ir[15:13] == 3'b101) begin
      if (ir[15:13] == 3'b101) begin
        c = b; c.readnum = ir[10:8]; c.loada = 1'b1;
        exp_q.push_back(c);
      end
      c = b; c.readnum = ir[2:0]; c.loadb = 1'b1;
      exp_q.push_back(c);
      c = b; c.loadc = 1'b1;
      c.asel  = (key == 5'b11000);
      c.loads = (key == 5'b10101);
      exp_q.push_back(c);
      if (key != 5'b10101) begin
        c = b; c.writenum = ir[7:5]; c.write = 1'b1;
        exp_q.push_back(c);
      end
    end
  endfunction

  // Load (optionally in the same cycle as s), then walk and check every busy
  // cycle; with inject, junk load/s is driven throughout the busy period.
  task automatic run_instr(input string name, input logic [15:0] ir,
                           input bit same_cycle, input bit inject);
    if (!same_cycle) begin
      in = ir; load = 1'b1;
      tick();
      load = 1'b0;
      check($sformatf("%s_loaded", name), idle(ir));
    end
    in = ir; load = same_cycle; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    build_expect(ir);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (inject) begin
        in = 16'(ir ^ 16'h5A5A ^ 16'($urandom)); load = 1'b1; s = 1'b1;
      end
      check($sformatf("%s[%0d]", name, i), exp_q[i]);
      tick();
    end
    load = 1'b0; s = 1'b0;
    check($sformatf("%s_done", name), idle(ir));
  endtask

  logic [15:0] rir;
  int          kind;

  initial begin
    reset = 1'b1; in = 16'd0; load = 1'b0; s = 1'b0;
    #3;
    check("reset_state", idle(16'd0));
    #9 reset = 1'b0;
    tick();
    check("after_reset", idle(16'd0));
    tick();
    check("idle_no_s", idle(16'd0));

    run_instr("mov_imm", 16'hD0FD, 1'b0, 1'b0);
    run_instr("add", 16'hA148, 1'b0, 1'b0);
    run_instr("cmp", 16'hA900, 1'b0, 1'b0);
    run_instr("undef", 16'hE000, 1'b0, 1'b0);
    run_instr("add_inject", 16'hA148, 1'b0, 1'b1);
    run_instr("load_s_same", 16'hD0FD, 1'b1, 1'b0);
    run_instr("mov_reg", 16'hC0B3, 1'b0, 1'b0);

    // Reset asserted mid-EXEC of ADD.
    in = 16'hA148; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    build_expect(16'hA148);
    tick(); tick(); tick();
    check("add_exec_pre_reset", exp_q[3]);
    #2 reset = 1'b1;
    #1 check("reset_mid_exec", idle(16'd0));
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset_wait%0d", i), idle(16'd0));
    end

    // Randomized instruction mix against the reference model.
    for (int n = 0; n < 60; n++) begin
      rir  = 16'($urandom);
      kind = $urandom_range(0, 5);
      case (kind)
        0: rir[15:11] = 5'b11010;
        1: rir[15:11] = 5'b11000;
        2: rir[15:13] = 3'b101;
        3: rir[15:11] = 5'b10101;
        4: ;
        default: rir[15:11] = {3'b110, 1'($urandom), 1'b1};
      endcase
      run_instr($sformatf("rnd%0d", n), rir, 1'($urandom), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        tick();
        check($sformatf("rnd%0d_idle%0d", n, k), idle(rir));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
